// File: rtl/mult_div_unit.sv
// Multiply/divide responder for the E-stage Start/Busy handshake; owns HI/LO.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) enabled by `define MULT_ACC_EN.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        IntReq,
  input  logic [3:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULT_ACC_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [DW-1:0] phi;
  logic [DW-1:0] plo;
  logic          pend_wr;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;
  logic [DW-1:0] sq;
  logic [DW-1:0] sr;
  logic [DW-1:0] uq;
  logic [DW-1:0] ur;
  logic [DW-1:0] safe_b;
  logic [DW-1:0] safe_mag_b;
  logic [63:0]   result;
  logic          launch;
  logic          div_zero;
  logic [CW-1:0] cycles;

  // Full-width products; signed product taken mod 2^64 of sign-extended operands.
  always_comb begin
    prod_s = {{DW{A[DW-1]}}, A} * {{DW{B[DW-1]}}, B};
    prod_u = {{DW{1'b0}}, A} * {{DW{1'b0}}, B};
  end

  // Signed divide via magnitudes so the most-negative / -1 case wraps cleanly.
  always_comb begin
    mag_a      = A[DW-1] ? (~A + 32'd1) : A;
    mag_b      = B[DW-1] ? (~B + 32'd1) : B;
    safe_b     = (B == '0) ? 32'd1 : B;
    safe_mag_b = (mag_b == '0) ? 32'd1 : mag_b;
    uq         = A / safe_b;
    ur         = A % safe_b;
    sq         = mag_a / safe_mag_b;
    sr         = mag_a % safe_mag_b;
    if (A[DW-1] ^ B[DW-1]) sq = ~sq + 32'd1;
    if (A[DW-1])           sr = ~sr + 32'd1;
  end

  // Op decode: launch qualifier, latency and pending result.
  always_comb begin
    launch   = 1'b0;
    div_zero = 1'b0;
    cycles   = '0;
    result   = '0;
    case (MDop)
      OP_MULT:  begin launch = 1'b1; cycles = CW'(MULT_CYCLES); result = prod_s; end
      OP_MULTU: begin launch = 1'b1; cycles = CW'(MULT_CYCLES); result = prod_u; end
      OP_DIV: begin
        launch = 1'b1; cycles = CW'(DIV_CYCLES); div_zero = (B == '0);
        result = {sr, sq};
      end
      OP_DIVU: begin
        launch = 1'b1; cycles = CW'(DIV_CYCLES); div_zero = (B == '0);
        result = {ur, uq};
      end
`ifdef MULT_ACC_EN
      OP_MADD:  begin launch = 1'b1; cycles = CW'(MULT_CYCLES); result = {HI, LO} + prod_s; end
      OP_MADDU: begin launch = 1'b1; cycles = CW'(MULT_CYCLES); result = {HI, LO} + prod_u; end
      OP_MSUB:  begin launch = 1'b1; cycles = CW'(MULT_CYCLES); result = {HI, LO} - prod_s; end
      OP_MSUBU: begin launch = 1'b1; cycles = CW'(MULT_CYCLES); result = {HI, LO} - prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      phi     <= '0;
      plo     <= '0;
      pend_wr <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!IntReq) begin
            if (Start && launch) begin
              phi     <= result[63:32];
              plo     <= result[31:0];
              pend_wr <= !div_zero;
              counter <= cycles;
              Busy    <= 1'b1;
              state   <= RUN;
            end else if (!Start && MDop == OP_MTHI) begin
              HI <= A;
            end else if (!Start && MDop == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          counter <= counter - CW'(1);
          // Final busy cycle: commit unless this was a divide by zero.
          if (counter == CW'(1)) begin
            if (pend_wr) begin
              HI <= phi;
              LO <= plo;
            end
            pend_wr <= 1'b0;
            Busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
